// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider: one start pulse, bounded wait for done, then HI/LO write strobes.
// Latency: WRITE at acceptance + 3 + k, where k is the WAIT cycle in which done is first seen.
// Backpressure: op_ready only in IDLE; requests while busy are dropped, not queued.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_sel,
  input  logic        abort,
  output logic        op_ready,
  output logic        busy,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [63:0] mult_result,
  output logic        div_start,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_by_zero,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        done,
  output logic        exc_div_zero,
  output logic        exc_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sel_q;
  logic             unit_done;

  // Only the unit that was actually started may end the wait; the other one's done is noise.
  assign unit_done = sel_q ? div_done : mult_done;

  // Sequencer state, wait counter, latched operation and captured results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sel_q        <= 1'b0;
      hi_data      <= '0;
      lo_data      <= '0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
    end else begin
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            sel_q <= op_sel;
            state <= S_START;
          end
        end
        S_START: begin
          // The start pulse is already out this cycle; abort only skips the wait.
          cnt   <= '0;
          state <= abort ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (unit_done) begin
            if (sel_q && div_by_zero) begin
              exc_div_zero <= 1'b1;
              state        <= S_IDLE;
            end else begin
              if (sel_q) begin
                hi_data <= div_remainder;
                lo_data <= div_quotient;
              end else begin
                hi_data <= mult_result[63:32];
                lo_data <= mult_result[31:0];
              end
              state <= S_WRITE;
            end
          end else if (cnt == CNT_LAST) begin
            exc_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          // Results are committed; abort has nothing left to cancel.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign op_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign mult_start = (state == S_START) && !sel_q;
  assign div_start  = (state == S_START) &&  sel_q;
  assign hi_write   = (state == S_WRITE);
  assign lo_write   = (state == S_WRITE);
  assign done       = (state == S_WRITE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed stimulus against a transaction-level outcome model of muldiv_sequencer.
// Latency: each operation is observed over a fixed window long enough to cover the timeout.
// Backpressure: extra requests are driven while busy and must not start a second operation.
module tb_muldiv_sequencer;

  localparam int T    = 40;
  localparam int NONE = -99;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_sel, abort;
  logic        op_ready, busy, mult_start, div_start;
  logic        mult_done, div_done, div_by_zero;
  logic [63:0] mult_result;
  logic [31:0] div_quotient, div_remainder;
  logic        hi_write, lo_write, done, exc_div_zero, exc_timeout;
  logic [31:0] hi_data, lo_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_sel(op_sel), .abort(abort),
    .op_ready(op_ready), .busy(busy), .mult_start(mult_start), .mult_done(mult_done),
    .mult_result(mult_result), .div_start(div_start), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_by_zero(div_by_zero),
    .hi_write(hi_write), .lo_write(lo_write), .hi_data(hi_data), .lo_data(lo_data),
    .done(done), .exc_div_zero(exc_div_zero), .exc_timeout(exc_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    op_valid = 0; op_sel = 0; abort = 0; mult_done = 0; div_done = 0; div_by_zero = 0;
    mult_result = '0; div_quotient = '0; div_remainder = '0;
  endtask

  // One operation: the model predicts the outcome and its cycle from the event cycles alone.
  // Cycle t=1 is START; WAIT cycle k is t=k+2. abort_k=-1 means abort during START.
  task automatic run_op(input bit sel, input int done_k, input int abort_k, input bit dbz,
                        input logic [63:0] res, input logic [31:0] q, input logic [31:0] r,
                        input int stray_k, input bit extra);
    int end_t, ev_t, kind; // kind: 0 abort, 1 write, 2 divide-by-zero, 3 timeout
    int n_ms, n_ds, n_hw, n_lw, n_dn, n_ez, n_et, t_wr, t_ez, t_et, t_rdy, n_busy_lo;
    int k;
    if (abort_k == -1) begin
      kind = 0; end_t = 2; ev_t = NONE;
    end else if (abort_k != NONE && abort_k <= done_k && abort_k <= T - 1) begin
      kind = 0; end_t = abort_k + 3; ev_t = NONE;
    end else if (done_k <= T - 1) begin
      kind  = (sel && dbz) ? 2 : 1;
      ev_t  = done_k + 3;
      end_t = (kind == 1) ? done_k + 4 : done_k + 3;
    end else begin
      kind = 3; ev_t = T + 2; end_t = T + 2;
    end

    chk("ready_before_op", 64'(op_ready), 64'(1));
    op_valid = 1; op_sel = sel;
    @(posedge clk); #1;
    op_valid = 0; op_sel = 1'($urandom);
    n_ms = 0; n_ds = 0; n_hw = 0; n_lw = 0; n_dn = 0; n_ez = 0; n_et = 0; n_busy_lo = 0;
    t_wr = NONE; t_ez = NONE; t_et = NONE; t_rdy = NONE;
    for (int t = 1; t <= T + 6; t++) begin
      k = t - 2;
      mult_done     = (k >= 0) && ((!sel && k == done_k) || (sel && k == stray_k));
      div_done      = (k >= 0) && (( sel && k == done_k) || (!sel && k == stray_k));
      div_by_zero   = dbz;
      abort         = (abort_k != NONE) && (k == abort_k);
      op_valid      = extra && (t == 2 || t == 3) && (end_t > t);
      op_sel        = 1'($urandom);
      mult_result   = (k == done_k) ? res : {$urandom, $urandom};
      div_quotient  = (k == done_k) ? q : $urandom;
      div_remainder = (k == done_k) ? r : $urandom;
      @(negedge clk);
      n_ms += int'(mult_start); n_ds += int'(div_start);
      n_hw += int'(hi_write);   n_lw += int'(lo_write);  n_dn += int'(done);
      n_ez += int'(exc_div_zero); n_et += int'(exc_timeout);
      if (hi_write && t_wr == NONE) t_wr = t;
      if (exc_div_zero && t_ez == NONE) t_ez = t;
      if (exc_timeout && t_et == NONE) t_et = t;
      if (op_ready && t_rdy == NONE) t_rdy = t;
      if (t < end_t && !busy) n_busy_lo++;
      @(posedge clk); #1;
    end
    clear_inputs();

    chk("mult_start_count", 64'(n_ms), 64'(sel ? 0 : 1));
    chk("div_start_count", 64'(n_ds), 64'(sel ? 1 : 0));
    chk("hi_write_count", 64'(n_hw), 64'(kind == 1 ? 1 : 0));
    chk("lo_write_count", 64'(n_lw), 64'(kind == 1 ? 1 : 0));
    chk("done_count", 64'(n_dn), 64'(kind == 1 ? 1 : 0));
    chk("exc_div_zero_count", 64'(n_ez), 64'(kind == 2 ? 1 : 0));
    chk("exc_timeout_count", 64'(n_et), 64'(kind == 3 ? 1 : 0));
    if (kind == 1) chk("write_cycle", 64'(t_wr), 64'(ev_t));
    if (kind == 2) chk("div_zero_cycle", 64'(t_ez), 64'(ev_t));
    if (kind == 3) chk("timeout_cycle", 64'(t_et), 64'(ev_t));
    chk("ready_return_cycle", 64'(t_rdy), 64'(end_t));
    chk("busy_while_active", 64'(n_busy_lo), 64'(0));
    if (kind == 1) begin
      if (sel) begin exp_hi = r; exp_lo = q; end
      else     begin exp_hi = res[63:32]; exp_lo = res[31:0]; end
    end
    chk("hi_data", 64'(hi_data), 64'(exp_hi));
    chk("lo_data", 64'(lo_data), 64'(exp_lo));
  endtask

  initial begin
    int dk, ak, sk;
    bit s;
    clear_inputs();
    reset = 1;
    #12;
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_strobes", 64'({mult_start, div_start, hi_write, lo_write, done, exc_div_zero, exc_timeout}), 64'(0));
    chk("rst_hi", 64'(hi_data), 64'(0));
    chk("rst_lo", 64'(lo_data), 64'(0));
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Directed: MULT done in 5th WAIT cycle.
    run_op(0, 4, NONE, 0, 64'h0000_0001_FFFF_FFFE, 0, 0, NONE, 0);
    // DIV done immediately, stray mult_done during WAIT.
    run_op(1, 0, NONE, 0, 0, 32'd7, 32'd3, 0, 0);
    // MULT leaving hi=1 lo=2, then divide by zero.
    run_op(0, 2, NONE, 0, 64'h0000_0001_0000_0002, 0, 0, NONE, 0);
    run_op(1, 3, NONE, 1, 0, 32'd9, 32'd9, NONE, 0);
    // Timeout, then done on the very last count.
    run_op(0, 1000, NONE, 0, 0, 0, 0, NONE, 0);
    run_op(0, T - 1, NONE, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, NONE, 0);
    // Abort coincident with div_done, extra request while busy.
    run_op(1, 2, 2, 0, 0, 32'd5, 32'd6, NONE, 1);
    // Abort during START, and abort on the timeout count.
    run_op(0, 3, -1, 0, 64'h1234, 0, 0, NONE, 0);
    run_op(1, 1000, T - 1, 0, 0, 0, 0, NONE, 0);

    // Asynchronous reset mid-WAIT.
    op_valid = 1; op_sel = 0;
    @(posedge clk); #1;
    op_valid = 0;
    repeat (4) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_ready", 64'(op_ready), 64'(1));
    chk("async_rst_hi", 64'(hi_data), 64'(0));
    chk("async_rst_lo", 64'(lo_data), 64'(0));
    exp_hi = 0; exp_lo = 0;
    @(posedge clk); #1;
    reset = 0;
    mult_done = 1; mult_result = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("late_done_no_write", 64'({hi_write, done, busy}), 64'(0));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("late_done_idle", 64'({hi_write, done, busy, hi_data}), 64'(0));
    @(posedge clk); #1;
    run_op(0, 0, NONE, 0, 64'h0000_00AA_0000_00BB, 0, 0, NONE, 0);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      s  = 1'($urandom);
      dk = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 45));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) - 1 : NONE;
      sk = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 10)) : NONE;
      run_op(s, dk, ak, s && ($urandom_range(0, 3) == 0), {$urandom, $urandom},
             $urandom, $urandom, sk, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier and divider for MULT/DIV instructions on behalf of the main control unit.
- Accepts one operation request and issues a single-cycle start to the selected unit.
- Waits for that unit's done, with a timeout, then issues one-cycle HI/LO write strobes with the captured results.
- Reports busy, completion, divide-by-zero and timeout, so the control unit can stall and raise exceptions.

Parameters:
- TIMEOUT_CYCLES, 40, maximum WAIT cycles allowed before a timeout is declared. Must be ≥ 2.
- CNT_W, 6, width of the wait counter. Requires 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  operation request, sampled in IDLE.
- op_sel  in  1  0 = MULT, 1 = DIV; latched on acceptance.
- abort  in  1  synchronous cancel of the in-flight operation.
- op_ready  out  1  high only in IDLE.
- busy  out  1  high in any state other than IDLE.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_done  in  1  multiplier done.
- mult_result  in  64  multiplier product.
- div_start  out  1  one-cycle start pulse to the divider.
- div_done  in  1  divider done.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- div_by_zero  in  1  divider zero-divisor flag, valid with div_done.
- hi_write  out  1  HI write strobe.
- lo_write  out  1  LO write strobe.
- hi_data  out  32  registered HI value.
- lo_data  out  32  registered LO value.
- done  out  1  one-cycle successful-completion pulse.
- exc_div_zero  out  1  one-cycle divide-by-zero exception pulse.
- exc_timeout  out  1  one-cycle timeout exception pulse.

Behaviour:
- Reset (asynchronous, active-high; clk is the clock):
  - State goes to IDLE; counter, latched op_sel, hi_data and lo_data clear to 0.
  - All strobes and pulses are 0; busy = 0; op_ready = 1.
  - Reset in any state aborts the operation with no writes and no pulses.
- States: IDLE, START, WAIT, WRITE. All outputs are registered or decoded from the state only; there is no combinational path from any input to any output.
- IDLE:
  - If op_valid = 1, latch op_sel and go to START next cycle.
  - If op_valid = 0, stay in IDLE.
- START:
  - Exactly one cycle: mult_start = 1 if latched op_sel = 0, else div_start = 1.
  - Counter clears to 0; go to WAIT.
- WAIT: evaluated each cycle in this priority order.
  1. abort = 1: go to IDLE with no writes and no pulses.
  2. The selected unit's done = 1:
     - MULT: capture hi_data = mult_result[63:32], lo_data = mult_result[31:0]; go to WRITE.
     - DIV with div_by_zero = 0: capture hi_data = div_remainder, lo_data = div_quotient; go to WRITE.
     - DIV with div_by_zero = 1: pulse exc_div_zero for one cycle (registered, in the next cycle); hi_data/lo_data unchanged; go to IDLE.
  3. Counter = TIMEOUT_CYCLES − 1: pulse exc_timeout for one cycle (next cycle); go to IDLE with no write.
  4. Otherwise: counter increments by 1.
- done from the non-selected unit is ignored in every state.
- done arriving in the same cycle as the timeout count wins over the timeout.
- WRITE:
  - One cycle with hi_write = lo_write = done = 1; hi_data/lo_data hold the captured values; then go to IDLE.
  - abort in WRITE is ignored (the write has already been committed).
- abort in IDLE or START:
  - IDLE: no effect.
  - START: the start pulse still issues this cycle; next state is IDLE.
- op_valid while busy is ignored, not queued.
- hi_data/lo_data hold their last captured value until the next successful capture.
- Latency, with acceptance at edge 0:
  - START is the cycle after edge 0.
  - With done first seen in WAIT cycle k (k = 0 is the first WAIT cycle), WRITE is 3 + k cycles after acceptance.
  - op_ready is high again the cycle after WRITE.
  - Minimum turnaround is 4 cycles (acceptance to op_ready).

Test Plan:
1. MULT, mult_done asserted in the 5th WAIT cycle with mult_result = 64'h0000_0001_FFFF_FFFE -> one mult_start pulse, div_start never asserted; one cycle of hi_write = lo_write = done = 1 with hi_data = 32'h1, lo_data = 32'hFFFF_FFFE; op_ready returns high.
2. DIV, quotient = 7, remainder = 3, div_done in the 1st WAIT cycle -> WRITE at acceptance + 3 with hi_data = 3, lo_data = 7; a stray mult_done pulse during WAIT is ignored.
3. DIV with div_done = div_by_zero = 1 after a prior MULT that left hi = 1, lo = 2 -> exc_div_zero one cycle; no hi_write/lo_write; hi_data = 1 and lo_data = 2 unchanged; back in IDLE.
4. MULT with mult_done never asserted, TIMEOUT_CYCLES = 40 -> exc_timeout pulses once after 40 WAIT cycles; no write or done. Second run with mult_done arriving in the same cycle as the timeout count -> WRITE occurs and no exc_timeout.
5. abort in WAIT coincident with div_done -> no write, no pulses, IDLE next cycle. A second op_valid pulse driven while busy is not executed.
6. Asynchronous reset asserted mid-WAIT -> busy drops immediately; hi_data/lo_data = 0. A subsequent late mult_done produces no write; a new request after reset completes normally.
